// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for the data-memory arbiter.
// The requester drives req/payload; the arbiter answers with gnt and a one-cycle response.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One access in flight at a time: IDLE -> ACCESS -> RESP, or IDLE -> RESP for rejected requests.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave a,
    dmem_arbiter_if.slave b,
    output logic [31:0]   data_addr,
    output logic [31:0]   data_write,
    output logic [3:0]    data_write_byte,
    output logic          data_read_valid,
    output logic          data_write_valid,
    input  logic [31:0]   data_read
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q;
    logic        last_b_q;
    logic        win_b_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_data_q;

    // Rejects out-of-range words, misaligned reads and strobes that are not a naturally
    // aligned byte, halfword or word matching the low address bits.
    function automatic logic req_bad(input logic we, input logic [31:0] addr,
                                     input logic [3:0] wstrb);
        logic [32:0] last_byte;
        logic        bad;
        last_byte = {1'b0, addr[31:2], 2'b00} + 33'd3;
        bad = (last_byte >= 33'(MEM_BYTES));
        if (we) begin
            case (wstrb)
                4'b0001, 4'b0011, 4'b1111: bad = bad | (addr[1:0] != 2'd0);
                4'b0010:                   bad = bad | (addr[1:0] != 2'd1);
                4'b0100, 4'b1100:          bad = bad | (addr[1:0] != 2'd2);
                4'b1000:                   bad = bad | (addr[1:0] != 2'd3);
                default:                   bad = 1'b1;
            endcase
        end else begin
            bad = bad | (addr[1:0] != 2'd0);
        end
        return bad;
    endfunction

    logic        sel_b;
    logic        grant;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        sel_err;

    // Tie goes to whichever port did not win last time.
    assign sel_b     = b.req & (~a.req | ~last_b_q);
    assign grant     = (state_q == StIdle) & reset & (a.req | b.req);
    assign sel_we    = sel_b ? b.we    : a.we;
    assign sel_addr  = sel_b ? b.addr  : a.addr;
    assign sel_wdata = sel_b ? b.wdata : a.wdata;
    assign sel_wstrb = sel_b ? b.wstrb : a.wstrb;
    assign sel_err   = req_bad(sel_we, sel_addr, sel_wstrb);

    assign a.gnt    = grant & ~sel_b;
    assign b.gnt    = grant & sel_b;
    assign a.rvalid = rsp_valid_q & ~win_b_q;
    assign b.rvalid = rsp_valid_q & win_b_q;
    assign a.err    = a.rvalid & rsp_err_q;
    assign b.err    = b.rvalid & rsp_err_q;
    assign a.rdata  = a.rvalid ? rsp_data_q : 32'd0;
    assign b.rdata  = b.rvalid ? rsp_data_q : 32'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= StIdle;
            last_b_q         <= 1'b1;
            win_b_q          <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_err_q        <= 1'b0;
            rsp_data_q       <= 32'd0;
            data_addr        <= 32'd0;
            data_write       <= 32'd0;
            data_write_byte  <= 4'd0;
            data_read_valid  <= 1'b0;
            data_write_valid <= 1'b0;
        end else begin
            // Memory-side payload lives only for the single ACCESS cycle.
            data_addr        <= 32'd0;
            data_write       <= 32'd0;
            data_write_byte  <= 4'd0;
            data_read_valid  <= 1'b0;
            data_write_valid <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_err_q        <= 1'b0;
            rsp_data_q       <= 32'd0;
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        last_b_q <= sel_b;
                        win_b_q  <= sel_b;
                        if (sel_err) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q          <= StAccess;
                            data_addr        <= {sel_addr[31:2], 2'b00};
                            data_write       <= sel_wdata;
                            data_write_byte  <= sel_we ? sel_wstrb : 4'd0;
                            data_write_valid <= sel_we;
                            data_read_valid  <= ~sel_we;
                        end
                    end
                end
                StAccess: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= data_write_valid ? 32'd0 : data_read;
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle-exact checks of grant, memory strobes and responses
// against a byte-lane memory model.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] data_addr;
    logic [31:0] data_write;
    logic [3:0]  data_write_byte;
    logic        data_read_valid;
    logic        data_write_valid;
    logic [31:0] data_read;

    dmem_arbiter_if a_if ();
    dmem_arbiter_if b_if ();

    dmem_arbiter #(
        .MEM_BYTES(128)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .a               (a_if.slave),
        .b               (b_if.slave),
        .data_addr       (data_addr),
        .data_write      (data_write),
        .data_write_byte (data_write_byte),
        .data_read_valid (data_read_valid),
        .data_write_valid(data_write_valid),
        .data_read       (data_read)
    );

    logic [31:0] mem [32];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end

    assign data_read = mem[data_addr[6:2]];

    always @(posedge clk) begin
        if (data_write_valid) begin
            for (int j = 0; j < 4; j++) begin
                if (data_write_byte[j]) mem[data_addr[6:2]][8*j +: 8] <= data_write[8*j +: 8];
            end
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{a_if.gnt, a_if.rvalid, a_if.rdata, a_if.err, b_if.gnt, b_if.rvalid, b_if.rdata,
                 b_if.err, data_addr, data_write, data_write_byte, data_read_valid,
                 data_write_valid};
    endfunction

    task automatic set_req(input bit pb, input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        if (pb) begin
            b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata; b_if.wstrb = wstrb;
        end else begin
            a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata; a_if.wstrb = wstrb;
        end
    endtask

    function automatic logic gnt_of(input bit pb);
        return pb ? b_if.gnt : a_if.gnt;
    endfunction

    function automatic logic rvalid_of(input bit pb);
        return pb ? b_if.rvalid : a_if.rvalid;
    endfunction

    // One isolated transaction from port pb, checked every cycle from grant to return to idle.
    task automatic single(input string tag, input bit pb, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic exp_err, input logic [31:0] exp_rdata);
        @(negedge clk);
        set_req(pb, 1'b1, we, addr, wdata, wstrb);
        #1;
        check({tag, "_gnt"}, 32'(gnt_of(pb)), 32'd1);
        check({tag, "_gnt_other"}, 32'(gnt_of(!pb)), 32'd0);
        @(negedge clk);
        set_req(pb, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        if (!exp_err) begin
            check({tag, "_wvalid"}, 32'(data_write_valid), 32'(we));
            check({tag, "_rdvalid"}, 32'(data_read_valid), 32'(!we));
            check({tag, "_daddr"}, data_addr, {addr[31:2], 2'b00});
            check({tag, "_dstrb"}, 32'(data_write_byte), we ? 32'(wstrb) : 32'd0);
            if (we) check({tag, "_dwrite"}, data_write, wdata);
            check({tag, "_early_rvalid"}, 32'(rvalid_of(pb)), 32'd0);
            @(negedge clk);
            #1;
        end
        check({tag, "_rvalid"}, 32'(rvalid_of(pb)), 32'd1);
        check({tag, "_err"}, 32'(pb ? b_if.err : a_if.err), 32'(exp_err));
        check({tag, "_rdata"}, pb ? b_if.rdata : a_if.rdata, exp_rdata);
        check({tag, "_other_rsp"}, 32'(|{rvalid_of(!pb), pb ? a_if.rdata : b_if.rdata,
                                         pb ? a_if.err : b_if.err}), 32'd0);
        check({tag, "_memvalid_resp"}, 32'(data_write_valid | data_read_valid), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_rvalid_drop"}, 32'(rvalid_of(pb)), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", 32'(any_out()), 32'd0);
        reset = 1'b1;

        // Both ports hammering: a, b, a, b every third cycle, nothing outside IDLE.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                set_req(1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 4'd0);
                set_req(1'b1, 1'b1, 1'b0, 32'h4, 32'd0, 4'd0);
            end
            #1;
            check($sformatf("rr_a_gnt_%0d", k), 32'(a_if.gnt),
                  32'((k % 3 == 0) && ((k / 3) % 2 == 0)));
            check($sformatf("rr_b_gnt_%0d", k), 32'(b_if.gnt),
                  32'((k % 3 == 0) && ((k / 3) % 2 == 1)));
        end
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        check("rr_idle_nogrant", 32'(a_if.gnt | b_if.gnt), 32'd0);

        single("wr10", 1'b0, 1'b1, 32'h10, 32'h12345678, 4'b1111, 1'b0, 32'd0);
        single("rd10", 1'b0, 1'b0, 32'h10, 32'd0, 4'd0, 1'b0, 32'h12345678);
        single("wr20", 1'b0, 1'b1, 32'h20, 32'h11111111, 4'b1111, 1'b0, 32'd0);
        single("b_bad_strb", 1'b1, 1'b1, 32'h21, 32'hFFFFFFFF, 4'b0011, 1'b1, 32'd0);
        single("rd20_unch", 1'b1, 1'b0, 32'h20, 32'd0, 4'd0, 1'b0, 32'h11111111);
        single("wr22_half", 1'b0, 1'b1, 32'h22, 32'hABCD0000, 4'b1100, 1'b0, 32'd0);
        single("rd20_half", 1'b0, 1'b0, 32'h20, 32'd0, 4'd0, 1'b0, 32'hABCD1111);
        single("rd80_oor", 1'b0, 1'b0, 32'h80, 32'd0, 4'd0, 1'b1, 32'd0);
        single("rd7c_edge", 1'b1, 1'b0, 32'h7C, 32'd0, 4'd0, 1'b0, 32'd0);
        single("rd7e_mis", 1'b0, 1'b0, 32'h7E, 32'd0, 4'd0, 1'b1, 32'd0);
        single("wr_strb0101", 1'b0, 1'b1, 32'h10, 32'd0, 4'b0101, 1'b1, 32'd0);
        single("wr_strb0000", 1'b1, 1'b1, 32'h10, 32'd0, 4'b0000, 1'b1, 32'd0);
        single("wr13_byte", 1'b0, 1'b1, 32'h13, 32'hEF000000, 4'b1000, 1'b0, 32'd0);
        single("rd10_byte", 1'b1, 1'b0, 32'h10, 32'd0, 4'd0, 1'b0, 32'hEF345678);

        // Reset landing in ACCESS aborts the read; a request under reset is not granted.
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
        #1;
        check("abort_gnt", 32'(a_if.gnt), 32'd1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        check("abort_access", 32'(data_read_valid), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
        #1;
        check("abort_outputs_zero", 32'(any_out()), 32'd0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        reset = 1'b1;
        #1;
        check("abort_no_rvalid", 32'(a_if.rvalid | data_read_valid), 32'd0);

        // Tie after reset release goes to a; b waits and is served next.
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
        set_req(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
        #1;
        check("tie_a_gnt", 32'(a_if.gnt), 32'd1);
        check("tie_b_wait", 32'(b_if.gnt), 32'd0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        check("tie_a_access", data_addr, 32'h10);
        @(negedge clk);
        #1;
        check("tie_a_rdata", a_if.rdata, 32'hEF345678);
        check("tie_b_gnt_resp", 32'(b_if.gnt), 32'd0);
        @(negedge clk);
        #1;
        check("tie_b_gnt", 32'(b_if.gnt), 32'd1);
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        #1;
        check("tie_b_rvalid", 32'(b_if.rvalid), 32'd1);
        check("tie_b_rdata", b_if.rdata, 32'hABCD1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 128, giving the data memory size in bytes; any address >= MEM_BYTES is out of range.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled at posedge clk.
REQ-004 Requester ports SHALL be provided twice, with prefix x = a (load/store unit) and x = b (debug/DMA), one line per signal as listed in REQ-005 to REQ-013.
REQ-005 x_req, input, 1 bit: access request; the requester holds the request and its payload until x_gnt.
REQ-006 x_we, input, 1 bit: 1 = write, 0 = read.
REQ-007 x_addr, input, 32 bits: byte address.
REQ-008 x_wdata, input, 32 bits: write data, already lane-positioned.
REQ-009 x_wstrb, input, 4 bits: write byte enables; ignored for reads.
REQ-010 x_gnt, output, 1 bit: request accepted; payload is captured this cycle.
REQ-011 x_rvalid, output, 1 bit: one-cycle completion pulse, for reads and writes.
REQ-012 x_rdata, output, 32 bits: read word; 0 for writes and errors.
REQ-013 x_err, output, 1 bit: qualifies x_rvalid; 1 = request rejected.
REQ-014 Memory-side ports SHALL be: data_addr output 32; data_write output 32; data_write_byte output 4; data_read_valid output 1; data_write_valid output 1; data_read input 32 (combinational read).

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP; reset state is IDLE.
REQ-016 In IDLE with any x_req=1, exactly one x_gnt SHALL be asserted combinationally in the same cycle T, and the payload, winner and error flag SHALL be registered at the end of T.
REQ-017 Arbitration SHALL be round-robin: on a tie, grant the port not granted last; the last-grant pointer resets to b, so a wins the first tie.
REQ-018 A request SHALL be erroneous if the address is out of range (any byte of the accessed word >= MEM_BYTES), or if it is a write and x_wstrb is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111, or if the index of the lowest set bit of x_wstrb != x_addr[1:0].
REQ-019 A read with x_addr[1:0] != 0 SHALL be erroneous.
REQ-020 A valid request SHALL follow IDLE(T) -> ACCESS(T+1) -> RESP(T+2) -> IDLE(T+3).
REQ-021 An erroneous request SHALL follow IDLE(T) -> RESP(T+1) -> IDLE(T+2) and SHALL never assert a memory valid.
REQ-022 In ACCESS only: data_addr = {addr[31:2], 2'b00}; data_write = wdata; data_write_byte = wstrb for writes and 0000 for reads; exactly one of data_write_valid/data_read_valid SHALL be 1, for exactly one cycle.
REQ-023 Outside ACCESS, all memory-side outputs SHALL be 0.
REQ-024 data_read SHALL be registered at the end of ACCESS into the response register.
REQ-025 In RESP, the winner's x_rvalid SHALL be 1 for one cycle, with x_rdata and x_err valid in that cycle; the other port's x_rvalid, x_rdata and x_err SHALL be 0.
REQ-026 x_gnt SHALL be 0 in ACCESS and RESP; a request arriving in those states waits, and no request is ever dropped.
REQ-027 Deasserting x_req before x_gnt SHALL withdraw the request with no side effects.
REQ-028 At most one access SHALL be outstanding; peak throughput is one access per 3 cycles.

Reset
REQ-029 When reset=0 at a posedge: state = IDLE, last-grant = b, payload and response registers = 0.
REQ-030 When reset=0, every output SHALL be 0 from the next cycle.
REQ-031 A reset asserted in ACCESS or RESP SHALL abort the access; no x_rvalid is issued for it, and memory valids are 0 from the next cycle.
REQ-032 A reset asserted in the same cycle as a request SHALL override it; the request is not granted.

Verification
REQ-033 Reset low 2 cycles, then a: write addr 0x10, wdata 0x12345678, strb 1111 -> a_gnt at T; data_write_valid=1 only at T+1 with data_addr 0x10; a_rvalid=1, a_err=0 at T+2; a subsequent read of 0x10 -> a_rdata 0x12345678.
REQ-034 a and b both requesting continuously after reset -> grants a, b, a, b at 3-cycle spacing, and no grant is ever asserted outside IDLE.
REQ-035 b: write addr 0x21, strb 0011 -> b_gnt at T; b_rvalid=1, b_err=1 at T+1; data_write_valid never asserted; memory word 0x20 unchanged.
REQ-036 a: read addr 0x80 with MEM_BYTES=128 -> a_err=1, a_rdata=0 at T+1; data_read_valid stays 0.
REQ-037 Word 0x20 = 0x11111111, then a: write addr 0x22, strb 1100, wdata 0xABCD0000 -> readback of 0x20 = 0xABCD1111.
REQ-038 Reset driven low during ACCESS of a read -> no a_rvalid; all outputs 0 on the next cycle; the next request after release completes normally with grant to a on a tie.
